// File: rtl/aximm_rand_chk.sv
// LFSR receive-data checker: regenerates the example generator's beat
// sequence from the seed and scores every accepted beat against it.
module aximm_rand_chk #(
   parameter int LEADER_MODE = 1,
   localparam int W = LEADER_MODE * 40
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         chk_start,
   input  logic [W-1:0] seed_in,
   input  logic [15:0]  num_beats,
   input  logic         din_valid,
   input  logic [W-1:0] din,
   output logic         din_ready,
   output logic         chk_busy,
   output logic         chk_done,
   output logic         chk_pass,
   output logic         err_pulse,
   output logic [15:0]  err_cnt,
   output logic [15:0]  first_err_idx,
   output logic [W-1:0] first_err_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t         state;
   logic [W-1:0]   exp_q;
   logic [15:0]    nbeats;
   logic [15:0]    beat_cnt;
   logic           mis_q;
   logic [15:0]    mis_idx;
   logic [W-1:0]   mis_data;
   logic           fb;
   logic [W-1:0]   exp_nxt;
   logic           accept;
   logic           mis;

   generate
      if (LEADER_MODE == 2) begin : g_half
         assign fb = exp_q[79] ^ exp_q[78] ^ exp_q[42] ^ exp_q[41];
      end else begin : g_full
         assign fb = exp_q[39] ^ exp_q[37] ^ exp_q[20] ^ exp_q[18];
      end
   endgenerate

   assign exp_nxt = {exp_q[W-2:0], fb};
   assign accept  = din_valid & din_ready;
   assign mis     = (din != exp_q);

   // Mismatches go through one pipeline stage (mis_q) before they
   // reach the error counters; chk_pass folds in the in-flight one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         exp_q          <= W'(1);
         nbeats         <= '0;
         beat_cnt       <= '0;
         mis_q          <= 1'b0;
         mis_idx        <= '0;
         mis_data       <= '0;
         din_ready      <= 1'b0;
         chk_busy       <= 1'b0;
         chk_done       <= 1'b0;
         chk_pass       <= 1'b0;
         err_pulse      <= 1'b0;
         err_cnt        <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else begin
         err_pulse <= 1'b0;
         mis_q     <= 1'b0;
         if (mis_q) begin
            err_pulse <= 1'b1;
            if (err_cnt != 16'hFFFF)
               err_cnt <= err_cnt + 16'd1;
            if (err_cnt == 16'd0) begin
               first_err_idx  <= mis_idx;
               first_err_data <= mis_data;
            end
         end
         unique case (state)
            IDLE, DONE: begin
               if (chk_start) begin
                  exp_q          <= seed_in;
                  nbeats         <= num_beats;
                  beat_cnt       <= '0;
                  err_cnt        <= '0;
                  err_pulse      <= 1'b0;
                  first_err_idx  <= '0;
                  first_err_data <= '0;
                  if (num_beats == 16'd0) begin
                     state    <= DONE;
                     chk_done <= 1'b1;
                     chk_pass <= 1'b1;
                  end else begin
                     state     <= CHECK;
                     din_ready <= 1'b1;
                     chk_busy  <= 1'b1;
                     chk_done  <= 1'b0;
                     chk_pass  <= 1'b0;
                  end
               end
            end
            CHECK: begin
               if (accept) begin
                  exp_q    <= exp_nxt;
                  beat_cnt <= beat_cnt + 16'd1;
                  mis_q    <= mis;
                  mis_idx  <= beat_cnt;
                  mis_data <= din;
                  if (beat_cnt == nbeats - 16'd1) begin
                     state     <= DONE;
                     din_ready <= 1'b0;
                     chk_busy  <= 1'b0;
                     chk_done  <= 1'b1;
                     chk_pass  <= (err_cnt == 16'd0) && !mis_q && !mis;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aximm_rand_chk.sv
// Directed bench for aximm_rand_chk: FULL and HALF instances side by side.
module tb_aximm_rand_chk;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        f_start = 0, f_valid = 0;
   logic [39:0] f_seed = 0, f_din = 0;
   logic [15:0] f_num = 0;
   logic        f_ready, f_busy, f_done, f_pass, f_pulse;
   logic [15:0] f_cnt, f_idx;
   logic [39:0] f_data;

   logic        h_start = 0, h_valid = 0;
   logic [79:0] h_seed = 0, h_din = 0;
   logic [15:0] h_num = 0;
   logic        h_ready, h_busy, h_done, h_pass, h_pulse;
   logic [15:0] h_cnt, h_idx;
   logic [79:0] h_data;

   int checks = 0;
   int errors = 0;

   aximm_rand_chk #(.LEADER_MODE(1)) u_full (
      .clk(clk), .rst_n(rst_n), .chk_start(f_start), .seed_in(f_seed),
      .num_beats(f_num), .din_valid(f_valid), .din(f_din),
      .din_ready(f_ready), .chk_busy(f_busy), .chk_done(f_done),
      .chk_pass(f_pass), .err_pulse(f_pulse), .err_cnt(f_cnt),
      .first_err_idx(f_idx), .first_err_data(f_data)
   );

   aximm_rand_chk #(.LEADER_MODE(2)) u_half (
      .clk(clk), .rst_n(rst_n), .chk_start(h_start), .seed_in(h_seed),
      .num_beats(h_num), .din_valid(h_valid), .din(h_din),
      .din_ready(h_ready), .chk_busy(h_busy), .chk_done(h_done),
      .chk_pass(h_pass), .err_pulse(h_pulse), .err_cnt(h_cnt),
      .first_err_idx(h_idx), .first_err_data(h_data)
   );

   task automatic start_full(input logic [39:0] s, input logic [15:0] n);
      f_start = 1; f_seed = s; f_num = n;
      @(negedge clk);
      f_start = 0;
   endtask

   task automatic start_half(input logic [79:0] s, input logic [15:0] n);
      h_start = 1; h_seed = s; h_num = n;
      @(negedge clk);
      h_start = 0;
   endtask

   task automatic send_full(input logic [39:0] d);
      f_valid = 1; f_din = d;
      @(negedge clk);
   endtask

   task automatic send_half(input logic [79:0] d);
      h_valid = 1; h_din = d;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 0;
      @(negedge clk);
      checks++;
      if ({f_ready, f_busy, f_done, f_pass, f_pulse, f_cnt, f_idx, f_data} !== '0) begin
         errors++;
         $display("FAIL reset_full got ready=%b busy=%b done=%b pass=%b cnt=%0h idx=%0h data=%0h want all 0",
                  f_ready, f_busy, f_done, f_pass, f_cnt, f_idx, f_data);
      end
      checks++;
      if ({h_ready, h_busy, h_done, h_pass, h_pulse, h_cnt, h_idx, h_data} !== '0) begin
         errors++;
         $display("FAIL reset_half got ready=%b busy=%b done=%b pass=%b cnt=%0h want all 0",
                  h_ready, h_busy, h_done, h_pass, h_cnt);
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_full_clean;
      logic [39:0] v [4] = '{40'h1, 40'h2, 40'h4, 40'h8};
      start_full(40'h1, 16'd4);
      checks++;
      if (f_ready !== 1'b1 || f_busy !== 1'b1 || f_done !== 1'b0) begin
         errors++;
         $display("FAIL clean_start got ready=%b busy=%b done=%b want 1 1 0", f_ready, f_busy, f_done);
      end
      for (int i = 0; i < 4; i++) begin
         send_full(v[i]);
         if (i == 2) begin
            checks++;
            if (f_done !== 1'b0) begin
               errors++;
               $display("FAIL clean_early_done got %b want 0", f_done);
            end
         end
      end
      // stray beat right after the last one must not be taken
      f_din = 40'h10;
      checks++;
      if (f_done !== 1'b1 || f_pass !== 1'b1 || f_ready !== 1'b0 || f_busy !== 1'b0) begin
         errors++;
         $display("FAIL clean_done got done=%b pass=%b ready=%b busy=%b want 1 1 0 0",
                  f_done, f_pass, f_ready, f_busy);
      end
      @(negedge clk);
      f_valid = 0;
      @(negedge clk);
      checks++;
      if (f_cnt !== 16'd0 || f_pass !== 1'b1 || f_done !== 1'b1) begin
         errors++;
         $display("FAIL clean_result got cnt=%0d pass=%b done=%b want 0 1 1", f_cnt, f_pass, f_done);
      end
   endtask

   task automatic test_full_corrupt;
      logic [39:0] v [4] = '{40'h1, 40'h2, 40'h5, 40'h8};
      int pulses = 0;
      start_full(40'h1, 16'd4);
      for (int i = 0; i < 4; i++) begin
         send_full(v[i]);
         pulses += int'(f_pulse);
      end
      f_valid = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pulses += int'(f_pulse);
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL corrupt_pulses got %0d want 1", pulses);
      end
      checks++;
      if (f_cnt !== 16'd1) begin
         errors++;
         $display("FAIL corrupt_cnt got %0d want 1", f_cnt);
      end
      checks++;
      if (f_idx !== 16'd2 || f_data !== 40'h5) begin
         errors++;
         $display("FAIL corrupt_first got idx=%0d data=%0h want 2 5", f_idx, f_data);
      end
      checks++;
      if (f_done !== 1'b1 || f_pass !== 1'b0) begin
         errors++;
         $display("FAIL corrupt_pass got done=%b pass=%b want 1 0", f_done, f_pass);
      end
   endtask

   task automatic test_gaps;
      logic [39:0] v [4] = '{40'h1, 40'h2, 40'h4, 40'h8};
      start_full(40'h1, 16'd4);
      for (int i = 0; i < 4; i++) begin
         send_full(v[i]);
         f_valid = 0;
         if (i < 3) begin
            for (int g = 0; g < 3; g++) begin
               // a start pulse mid-check must be ignored
               f_start = (i == 1 && g == 1);
               f_seed = 40'h99; f_num = 16'd1;
               @(negedge clk);
            end
            f_start = 0;
            checks++;
            if (f_done !== 1'b0 || f_ready !== 1'b1) begin
               errors++;
               $display("FAIL gaps_mid%0d got done=%b ready=%b want 0 1", i, f_done, f_ready);
            end
         end
      end
      @(negedge clk);
      checks++;
      if (f_done !== 1'b1 || f_pass !== 1'b1 || f_cnt !== 16'd0) begin
         errors++;
         $display("FAIL gaps_result got done=%b pass=%b cnt=%0d want 1 1 0", f_done, f_pass, f_cnt);
      end
   endtask

   task automatic test_zero;
      int seen_ready = 0;
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      start_full(40'h1, 16'd0);
      checks++;
      if (f_done !== 1'b1 || f_pass !== 1'b1) begin
         errors++;
         $display("FAIL zero_done got done=%b pass=%b want 1 1", f_done, f_pass);
      end
      f_valid = 1; f_din = 40'h3;
      for (int i = 0; i < 4; i++) begin
         seen_ready += int'(f_ready);
         @(negedge clk);
      end
      f_valid = 0;
      checks++;
      if (seen_ready != 0 || f_cnt !== 16'd0 || f_pass !== 1'b1) begin
         errors++;
         $display("FAIL zero_ready got ready_cycles=%0d cnt=%0d pass=%b want 0 0 1",
                  seen_ready, f_cnt, f_pass);
      end
   endtask

   task automatic test_half;
      start_half(80'h8000_0000_0000_0000_0000, 16'd2);
      send_half(80'h8000_0000_0000_0000_0000);
      send_half(80'h1);
      h_valid = 0;
      @(negedge clk);
      checks++;
      if (h_done !== 1'b1 || h_pass !== 1'b1 || h_cnt !== 16'd0) begin
         errors++;
         $display("FAIL half_clean got done=%b pass=%b cnt=%0d want 1 1 0", h_done, h_pass, h_cnt);
      end
      start_half(80'h8000_0000_0000_0000_0000, 16'd2);
      send_half(80'h8000_0000_0000_0000_0000);
      send_half(80'h2);
      h_valid = 0;
      @(negedge clk);
      checks++;
      if (h_pass !== 1'b0 || h_cnt !== 16'd1 || h_idx !== 16'd1 || h_data !== 80'h2) begin
         errors++;
         $display("FAIL half_corrupt got pass=%b cnt=%0d idx=%0d data=%0h want 0 1 1 2",
                  h_pass, h_cnt, h_idx, h_data);
      end
   endtask

   task automatic test_reset_mid;
      start_full(40'h1, 16'd4);
      send_full(40'h1);
      send_full(40'h3);
      f_valid = 0;
      #2 rst_n = 0;
      #1;
      checks++;
      if ({f_ready, f_busy, f_done, f_pass, f_pulse, f_cnt, f_idx, f_data} !== '0) begin
         errors++;
         $display("FAIL rstmid_clear got ready=%b busy=%b done=%b pass=%b cnt=%0d idx=%0d",
                  f_ready, f_busy, f_done, f_pass, f_cnt, f_idx);
      end
      @(negedge clk);
      rst_n = 1;
      f_valid = 1; f_din = 40'h4;
      repeat (3) @(negedge clk);
      f_valid = 0;
      @(negedge clk);
      checks++;
      if (f_ready !== 1'b0 || f_busy !== 1'b0 || f_done !== 1'b0 || f_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rstmid_stray got ready=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                  f_ready, f_busy, f_done, f_cnt);
      end
      start_full(40'h1, 16'd4);
      send_full(40'h1);
      send_full(40'h2);
      send_full(40'h4);
      send_full(40'h8);
      f_valid = 0;
      @(negedge clk);
      checks++;
      if (f_done !== 1'b1 || f_pass !== 1'b1 || f_cnt !== 16'd0) begin
         errors++;
         $display("FAIL rstmid_rerun got done=%b pass=%b cnt=%0d want 1 1 0", f_done, f_pass, f_cnt);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_full_clean();
      test_full_corrupt();
      test_gaps();
      test_zero();
      test_half();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aximm_rand_chk.md
# aximm_rand_chk

LFSR-based receive-data checker for the AXI4-MM full examples. It is the receive-side counterpart of the example random data generator. The checker regenerates the expected pseudo-random beat sequence locally from the same seed and polynomial. It compares every accepted beat against that sequence and reports pass/fail, an error count and the first failing beat. It sits at the read-data / write-data sink of the example traffic path.

## Interface
- LEADER_MODE, 1, data width selector: W = LEADER_MODE*40. 1 = FULL (40-bit), 2 = HALF (80-bit). Any other value is illegal.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset. Assertion clears all state immediately; deassertion is used synchronously to clk.
- chk_start  in  1  single-cycle pulse. Arms a new check and samples seed_in and num_beats.
- seed_in  in  W  first expected beat. Must equal the generator seed.
- num_beats  in  16  number of beats to check.
- din_valid  in  1  beat valid.
- din  in  W  received beat.
- din_ready  out  1  checker accepts beats.
- chk_busy  out  1  check in progress.
- chk_done  out  1  check complete. Held until the next chk_start or reset.
- chk_pass  out  1  meaningful when chk_done=1. High if zero mismatches.
- err_pulse  out  1  one-cycle pulse per mismatching beat.
- err_cnt  out  16  mismatch count. Saturates at 16'hFFFF.
- first_err_idx  out  16  beat index (0-based) of the first mismatch.
- first_err_data  out  W  received data of the first mismatch.

## Operation
- **LFSR.** The exp register is W bits and holds the next expected beat. The step function is next(x) = {x[W-2:0], fb}.
  - FULL: fb = x[39]^x[37]^x[20]^x[18].
  - HALF: fb = x[79]^x[78]^x[42]^x[41].
  - The expected sequence is seed, next(seed), next(next(seed)), and so on. This matches the generator, which outputs the seed first and then shifts once per cycle.
- **States:** IDLE, CHECK, DONE.
- **IDLE or DONE + chk_start:**
  - Load exp ← seed_in and nbeats ← num_beats.
  - Clear beat_cnt, err_cnt, first_err_idx, first_err_data, chk_done and chk_pass.
  - If num_beats = 0: go to DONE with chk_pass=1.
  - Otherwise: go to CHECK.
- **CHECK:**
  - din_ready=1 and chk_busy=1.
  - A beat is accepted when din_valid & din_ready.
  - On acceptance: compare din with exp, set exp ← next(exp), and increment beat_cnt.
  - On mismatch: err_pulse=1 next cycle and err_cnt increments (saturating).
  - If the mismatch is the first one (err_cnt was 0): capture first_err_idx ← beat_cnt and first_err_data ← din.
  - When the accepted beat has beat_cnt = nbeats-1: go to DONE, with chk_done=1 and chk_pass = (no mismatch including this beat).
- **DONE:** din_ready=0 and chk_busy=0. Results are held.
- **chk_start during CHECK** is ignored. Beats continue normally.
- **din_valid outside CHECK** is ignored. No state change.
- **exp is not advanced** on cycles without an accepted beat, so valid gaps are tolerated.
- **beat_cnt** is 16-bit. It never wraps because the check terminates at nbeats ≤ 65535.

## Timing
- **Reset values:** state IDLE, exp = 1, and all outputs 0 (din_ready, chk_busy, chk_done, chk_pass, err_pulse, err_cnt, first_err_idx, first_err_data).
- All outputs are registered.
- **Start:** chk_start at edge N gives din_ready/chk_busy = 1 from after edge N. The first beat can be accepted at edge N+1.
- **Per-beat result:** err_cnt, first_err_*, and err_pulse update at the edge after the accepting edge.
- **Completion:** the final beat accepted at edge M gives chk_done=1, chk_pass valid, din_ready=0 and chk_busy=0 after edge M.
  - Exactly nbeats beats are accepted. din_valid on the cycle after the final beat is not accepted.
- **num_beats = 0:** chk_done=1 and chk_pass=1 one edge after chk_start. din_ready never rises.
- **Reset mid-check:** all state returns to reset values asynchronously. A new chk_start is required afterwards.
- **Throughput:** one beat per cycle sustained.

## Test plan
- **FULL clean:** LEADER_MODE=1, seed 40'h1, num_beats 4. Drive beats 1, 2, 4, 8 back-to-back. Required: chk_done=1, chk_pass=1, err_cnt=0, and chk_done rises one cycle after the 4th beat.
- **FULL corrupt:** same stimulus with beat 2 driven as 40'h5. Required: one err_pulse, err_cnt=1, first_err_idx=2, first_err_data=40'h5, chk_pass=0. Beat 3 (value 8) is still checked against the correct expected value 8.
- **Gaps:** same as the FULL clean case with din_valid low for 3 cycles between each beat. Required: pass, and chk_done only after the 4th accepted beat.
- **Zero beats:** num_beats=0. Required: chk_done=1 and chk_pass=1 one cycle after chk_start, and din_ready stays 0.
- **HALF:** LEADER_MODE=2, seed 80'h8000_0000_0000_0000_0000, num_beats 2. Drive beats seed and then 80'h1. Required: pass.
- **Reset mid-check:** rst_n low after 2 of 4 beats. Required: all outputs 0 immediately, and stray din_valid afterwards has no effect. A new chk_start plus 4 correct beats gives a pass.
